// File: rtl/ff_d_pipe.sv
// ff_d_pipe: STAGES-deep, DW-wide register pipeline with per-stage valid
// bits and valid/ready flow control. Empty stages keep filling while the
// output is stalled (bubble collapse). Offers a synchronous flush and a
// registered occupancy count.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset (priority over flush/transfers)
//   i_flush  synchronous clear of all stage valids and the count
//   i_valid  upstream beat present
//   i_data   upstream data
//   o_ready  pipe accepts a beat this cycle
//   o_valid  beat present at the last stage
//   o_data   last-stage data
//   i_ready  downstream accepts this cycle
//   o_count  number of valid stages, 0..STAGES

// One register slice: holds a valid bit and its data word.
module ff_d_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          rdy,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          vld,
    output logic [DW-1:0] data
);
    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (flush) begin
            // Data is left in place; only the valid bit is dropped.
            vld <= 1'b0;
        end else if (rdy) begin
            vld <= in_vld;
            // Bubbles do not overwrite data, keeping o_data deterministic.
            if (in_vld) data <= in_data;
        end
    end
endmodule

module ff_d_pipe #(
    parameter  int DW     = 8,
    parameter  int STAGES = 3,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_ready,
    output logic [CW-1:0] o_count
);
    // Index 0 is the upstream side; index k+1 is the output of stage k.
    logic [STAGES:0]         vld_pipe;
    logic [STAGES:0][DW-1:0] dat_pipe;
    // rdy[k] enables stage k; rdy[STAGES] is the downstream ready.
    logic [STAGES:0]         rdy;
    logic                    in_fire;
    logic                    out_fire;
    logic [CW-1:0]           count;

    assign vld_pipe[0]  = i_valid & ~i_flush;
    assign dat_pipe[0]  = i_data;
    assign rdy[STAGES]  = i_ready;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // A stage can load if it is empty or its occupant moves on.
            // This chains i_ready combinationally through to o_ready.
            assign rdy[k] = ~vld_pipe[k+1] | rdy[k+1];

            ff_d_pipe_stage #(.DW(DW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush   (i_flush),
                .rdy     (rdy[k]),
                .in_vld  (vld_pipe[k]),
                .in_data (dat_pipe[k]),
                .vld     (vld_pipe[k+1]),
                .data    (dat_pipe[k+1])
            );
        end
    endgenerate

    assign o_ready  = rdy[0] & ~i_flush;
    assign o_valid  = vld_pipe[STAGES];
    assign o_data   = dat_pipe[STAGES];
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    // Occupancy tracks the valid bits exactly, so it cannot exceed STAGES.
    always_ff @(posedge clk) begin
        if (rst || i_flush) count <= '0;
        else                count <= count + CW'(in_fire) - CW'(out_fire);
    end

    assign o_count = count;
endmodule

// File: tb/tb_ff_d_pipe.sv
// Bench for ff_d_pipe: instance 0 is DW=8/STAGES=3, instance 1 is
// DW=8/STAGES=1. A reference model tracks each accepted beat as
// (data, position) and advances positions by the "move forward unless the
// beat ahead blocks you" rule; accepted data is pushed to a scoreboard
// queue and popped when the DUT delivers a beat.
module tb_ff_d_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rs[2], fl[2], iv[2], ir[2];
    logic [7:0] id[2];
    logic       ordy[2], ovld[2];
    logic [7:0] od[2];
    logic [1:0] cnt0;
    logic [0:0] cnt1;

    ff_d_pipe #(.DW(8), .STAGES(3)) dut3 (
        .clk(clk), .rst(rs[0]), .i_flush(fl[0]), .i_valid(iv[0]), .i_data(id[0]),
        .o_ready(ordy[0]), .o_valid(ovld[0]), .o_data(od[0]), .i_ready(ir[0]),
        .o_count(cnt0)
    );
    ff_d_pipe #(.DW(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rs[1]), .i_flush(fl[1]), .i_valid(iv[1]), .i_data(id[1]),
        .o_ready(ordy[1]), .o_valid(ovld[1]), .o_data(od[1]), .i_ready(ir[1]),
        .o_count(cnt1)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sbq[2][$];   // expected data, oldest first
    int         posq[2][$];  // stage index of each in-flight beat
    logic [7:0] last_d[2];   // data last landed in the output stage
    bit         known[2];
    bit         armed[2];

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic model_step(int k, int s, logic [31:0] cnt);
        bit ev, outf, inf;
        int lim, np;
        ev = (posq[k].size() > 0) && (posq[k][0] == s - 1);
        if (armed[k]) begin
            chk("o_valid", k, 32'(ovld[k]), 32'(ev));
            chk("o_count", k, cnt, posq[k].size());
            chk("o_ready", k, 32'(ordy[k]),
                32'(!fl[k] && (posq[k].size() < s || ir[k])));
            if (ev) chk("o_data", k, 32'(od[k]), 32'(sbq[k][0]));
            else if (known[k]) chk("o_data_idle", k, 32'(od[k]), 32'(last_d[k]));
        end
        if (rs[k]) begin
            sbq[k].delete(); posq[k].delete();
            last_d[k] = 8'h00; known[k] = 1'b1; armed[k] = 1'b1;
            return;
        end
        if (!armed[k]) return;
        outf = ev && ir[k];
        inf  = iv[k] && !fl[k] && (posq[k].size() < s || ir[k]);
        if (outf) begin
            void'(sbq[k].pop_front());
            void'(posq[k].pop_front());
        end
        if (fl[k]) begin
            sbq[k].delete(); posq[k].delete(); known[k] = 1'b0;
            return;
        end
        lim = s;
        for (int i = 0; i < posq[k].size(); i++) begin
            np = (posq[k][i] + 1 < lim - 1) ? posq[k][i] + 1 : lim - 1;
            posq[k][i] = np;
            lim = np;
        end
        if (inf) begin
            sbq[k].push_back(id[k]);
            posq[k].push_back(0);
        end
        if (posq[k].size() > 0 && posq[k][0] == s - 1) begin
            last_d[k] = sbq[k][0];
            known[k] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 3, {30'b0, cnt0});
        model_step(1, 1, {31'b0, cnt1});
    end

    task automatic cyc(int k, bit r, bit f, bit v, logic [7:0] d, bit rd);
        rs[k] = r; fl[k] = f; iv[k] = v; id[k] = d; ir[k] = rd;
        @(posedge clk); #1;
    endtask

    // Offer one beat and hold it until the pipe takes it.
    task automatic send(int k, logic [7:0] d, bit rd);
        bit acc;
        int n = 0;
        rs[k] = 1'b0; fl[k] = 1'b0; iv[k] = 1'b1; id[k] = d; ir[k] = rd;
        do begin
            @(negedge clk); acc = ordy[k];
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send_timeout inst%0d data=%0h got=not_accepted want=accepted", k, d);
        end
        iv[k] = 1'b0;
    endtask

    task automatic rnd(int k, int n, int rd_pct);
        bit pend = 1'b0, acc;
        logic [7:0] d = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1; d = 8'($urandom);
            end
            rs[k] = ($urandom_range(0, 99) == 0);
            fl[k] = ($urandom_range(0, 24) == 0);
            iv[k] = pend; id[k] = d;
            ir[k] = ($urandom_range(0, 99) < rd_pct);
            @(negedge clk); acc = iv[k] && ordy[k];
            @(posedge clk); #1;
            if (acc || rs[k] || fl[k]) pend = 1'b0;
        end
        rs[k] = 1'b0; fl[k] = 1'b0; iv[k] = 1'b0; ir[k] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rs[k] = 1'b1; fl[k] = 1'b0; iv[k] = 1'b1; id[k] = 8'hFF; ir[k] = 1'b1;
            armed[k] = 1'b0; known[k] = 1'b0; last_d[k] = 8'h00;
        end
        // Reset with a beat offered, then release.
        cyc(0, 1, 0, 1, 8'hFF, 1);
        cyc(0, 1, 0, 1, 8'hFF, 1);
        rs[1] = 1'b0; iv[1] = 1'b0;
        cyc(0, 0, 0, 0, 8'h00, 1);

        // Stream 0x01..0x0A at full rate, then drain.
        for (int i = 1; i <= 10; i++) send(0, 8'(i), 1'b1);
        repeat (5) cyc(0, 0, 0, 0, 8'h00, 1);

        // Backpressure until full, then one-cycle ready pulse.
        for (int i = 1; i <= 3; i++) send(0, 8'(8'hA0 + i), 1'b0);
        cyc(0, 0, 0, 1, 8'hA4, 0);
        cyc(0, 0, 0, 1, 8'hA4, 0);
        cyc(0, 0, 0, 1, 8'hA4, 1);
        repeat (5) cyc(0, 0, 0, 0, 8'h00, 1);

        // Bubble collapse under stall.
        cyc(0, 0, 0, 1, 8'h11, 0);
        cyc(0, 0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 1, 8'h22, 0);
        cyc(0, 0, 0, 0, 8'h00, 0);
        repeat (4) cyc(0, 0, 0, 0, 8'h00, 1);

        // Flush a full pipe while a beat is offered.
        for (int i = 1; i <= 3; i++) send(0, 8'(8'hB0 + i), 1'b0);
        cyc(0, 0, 1, 1, 8'h55, 0);
        cyc(0, 0, 0, 0, 8'h00, 0);
        send(0, 8'h66, 1'b1);
        repeat (4) cyc(0, 0, 0, 0, 8'h00, 1);

        // Reset with beats in flight.
        send(0, 8'hC1, 1'b0);
        send(0, 8'hC2, 1'b0);
        cyc(0, 1, 0, 0, 8'h00, 0);
        repeat (3) cyc(0, 0, 0, 0, 8'h00, 1);

        rnd(0, 300, 70);
        rnd(0, 200, 30);

        // Single-stage build.
        cyc(1, 1, 0, 1, 8'hFF, 1);
        cyc(1, 1, 0, 1, 8'hFF, 1);
        cyc(1, 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) send(1, 8'(8'h10 + i), 1'b1);
        repeat (2) cyc(1, 0, 0, 0, 8'h00, 1);
        send(1, 8'h20, 1'b0);
        cyc(1, 0, 0, 1, 8'h21, 0);
        cyc(1, 0, 0, 1, 8'h21, 1);
        repeat (2) cyc(1, 0, 0, 0, 8'h00, 1);
        rnd(1, 200, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
